// File: rtl/mult_pkg.sv
// Shared constants and FSM state encoding for the arbitrated shift-add multiplier.
package mult_pkg;

    localparam int unsigned WIDTH_DEFAULT = 16;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t RUN  = 2'd1;
    localparam state_t DONE = 2'd2;

endpackage

// File: rtl/mult_shift_add_dp.sv
// Shift-add multiplier datapath: operand registers, accumulator and bit counter.
module mult_shift_add_dp
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_i,
    input  logic               step_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    input  logic               id_i,
    output logic [2*WIDTH-1:0] acc_o,
    output logic               id_o,
    output logic               last_o
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0]   a_q, a_d;
    logic [2*WIDTH-1:0] b_q, b_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic               id_q, id_d;

    // a shifts right and b shifts left each step, so a_q[0] and b_q are always
    // bit i of the multiplier and (b << i) for the current step i.
    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        acc_d = acc_q;
        cnt_d = cnt_q;
        id_d  = id_q;
        if (load_i) begin
            a_d   = a_i;
            b_d   = {{WIDTH{1'b0}}, b_i};
            acc_d = '0;
            cnt_d = '0;
            id_d  = id_i;
        end else if (step_i) begin
            if (a_q[0]) begin
                acc_d = acc_q + b_q;
            end
            a_d   = a_q >> 1;
            b_d   = b_q << 1;
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
            cnt_q <= '0;
            id_q  <= 1'b0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            id_q  <= id_d;
        end
    end

    assign acc_o  = acc_q;
    assign id_o   = id_q;
    assign last_o = (cnt_q == CntW'(WIDTH - 1));

endmodule

// File: rtl/mult_arbiter_seq.sv
// Two-port round-robin arbiter in front of a sequential shift-add multiplier.
module mult_arbiter_seq
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in0_valid,
    output logic               in0_ready,
    input  logic [WIDTH-1:0]   in0_a,
    input  logic [WIDTH-1:0]   in0_b,
    input  logic               in1_valid,
    output logic               in1_ready,
    input  logic [WIDTH-1:0]   in1_a,
    input  logic [WIDTH-1:0]   in1_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_product,
    output logic               out_id,
    output logic               busy
);

    state_t state_q, state_d;
    logic   last_q, last_d;
    logic   idle;
    logic   grant_id;
    logic   accept;
    logic   dp_last;
    logic [WIDTH-1:0] sel_a, sel_b;

    assign idle = (state_q == IDLE);

    // Reset value of last_q is 1 so port 0 wins the first contested grant.
    always_comb begin
        grant_id = in1_valid;
        if (in0_valid && in1_valid) begin
            grant_id = ~last_q;
        end
    end

    assign accept    = idle && (in0_valid || in1_valid);
    assign in0_ready = idle && in0_valid && !grant_id;
    assign in1_ready = idle && in1_valid && grant_id;
    assign sel_a     = grant_id ? in1_a : in0_a;
    assign sel_b     = grant_id ? in1_b : in0_b;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = RUN;
                    last_d  = grant_id;
                end
            end
            RUN: begin
                if (dp_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    mult_shift_add_dp #(
        .WIDTH (WIDTH)
    ) u_dp (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (accept),
        .step_i (state_q == RUN),
        .a_i    (sel_a),
        .b_i    (sel_b),
        .id_i   (grant_id),
        .acc_o  (out_product),
        .id_o   (out_id),
        .last_o (dp_last)
    );

    assign out_valid = (state_q == DONE);
    assign busy      = !idle;

endmodule

// File: tb/tb_mult_arbiter_seq.sv
// Self-checking bench for mult_arbiter_seq: directed scenarios plus random traffic vs a model.
module tb_mult_arbiter_seq;

    localparam int W = 16;

    logic           clk;
    logic           rst_n;
    logic           in0_valid, in0_ready;
    logic [W-1:0]   in0_a, in0_b;
    logic           in1_valid, in1_ready;
    logic [W-1:0]   in1_a, in1_b;
    logic           out_valid, out_ready;
    logic [2*W-1:0] out_product;
    logic           out_id;
    logic           busy;

    mult_arbiter_seq #(
        .WIDTH (W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in0_valid   (in0_valid),
        .in0_ready   (in0_ready),
        .in0_a       (in0_a),
        .in0_b       (in0_b),
        .in1_valid   (in1_valid),
        .in1_ready   (in1_ready),
        .in1_a       (in1_a),
        .in1_b       (in1_b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_product (out_product),
        .out_id      (out_id),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_tests;
    int          n_fail;
    int          cyc;
    // Model: one transaction in flight, result due W+1 cycles after its accept.
    bit          m_busy;
    int          m_acc_cyc;
    logic [31:0] m_prod;
    bit          m_id;
    bit          m_last;
    bit          hs0, hs1;
    int          n_done;
    bit          grants[$];
    logic [31:0] prods[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_step();
        bit g;
        bit ov_exp;
        hs0 = 1'b0;
        hs1 = 1'b0;
        if (!rst_n) begin
            check_eq("rst_out_valid", out_valid, 0);
            check_eq("rst_busy", busy, 0);
            m_busy = 1'b0;
            m_last = 1'b1;
            return;
        end
        if (!m_busy) begin
            g = (in0_valid && in1_valid) ? !m_last : in1_valid;
            check_eq("in0_ready", in0_ready, in0_valid && !g);
            check_eq("in1_ready", in1_ready, in1_valid && g);
            check_eq("idle_out_valid", out_valid, 0);
            check_eq("idle_busy", busy, 0);
            if (in0_valid || in1_valid) begin
                m_busy    = 1'b1;
                m_acc_cyc = cyc;
                m_id      = g;
                m_last    = g;
                m_prod    = g ? 32'(in1_a) * 32'(in1_b) : 32'(in0_a) * 32'(in0_b);
                hs0       = !g;
                hs1       = g;
                grants.push_back(g);
            end
        end else begin
            check_eq("busy_in0_ready", in0_ready, 0);
            check_eq("busy_in1_ready", in1_ready, 0);
            check_eq("busy", busy, 1);
            ov_exp = (cyc - m_acc_cyc) >= W + 1;
            check_eq("out_valid", out_valid, ov_exp);
            if (ov_exp) begin
                check_eq("out_product", out_product, m_prod);
                check_eq("out_id", out_id, m_id);
                if (out_ready) begin
                    m_busy = 1'b0;
                    n_done++;
                    prods.push_back(out_product);
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        if (hs0) in0_valid = 1'b0;
        if (hs1) in1_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while ((m_busy || in0_valid || in1_valid) && k < budget) begin
            tick();
            k++;
        end
        check_eq("drain_timeout", m_busy || in0_valid || in1_valid, 0);
    endtask

    function automatic logic [W-1:0] rand_op();
        case ($urandom % 4)
            0:       return '0;
            1:       return '1;
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        int s;
        int k;
        int done_before;
        n_tests = 0;
        n_fail  = 0;
        cyc     = 0;
        m_busy  = 1'b0;
        m_last  = 1'b1;
        n_done  = 0;
        rst_n     = 1'b0;
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        in0_a = '0; in0_b = '0; in1_a = '0; in1_b = '0;
        out_ready = 1'b1;
        repeat (2) tick();
        check_eq("rst_out_product", out_product, 0);
        check_eq("rst_out_id", out_id, 0);
        rst_n = 1'b1;
        tick();

        // Both ports valid right after reset: port 0 first, then port 1.
        in0_a = 16'd2; in0_b = 16'd7; in0_valid = 1'b1;
        in1_a = 16'd4; in1_b = 16'd9; in1_valid = 1'b1;
        wait_idle(100);
        check_eq("both_grant0", grants[0], 0);
        check_eq("both_grant1", grants[1], 1);
        check_eq("both_prod0", prods[0], 14);
        check_eq("both_prod1", prods[1], 36);

        // Port 0 only: 3*5.
        in0_a = 16'd3; in0_b = 16'd5; in0_valid = 1'b1;
        wait_idle(60);
        check_eq("p0_prod", prods[prods.size()-1], 15);
        check_eq("p0_grant", grants[grants.size()-1], 0);

        // Port 1 only: all-ones squared.
        in1_a = 16'hFFFF; in1_b = 16'hFFFF; in1_valid = 1'b1;
        wait_idle(60);
        check_eq("p1_prod", prods[prods.size()-1], 32'hFFFE0001);
        check_eq("p1_grant", grants[grants.size()-1], 1);

        // Consumer stall for 10 cycles after the result appears.
        out_ready = 1'b0;
        in0_a = 16'h1234; in0_b = 16'h00AB; in0_valid = 1'b1;
        repeat (W + 11) tick();
        check_eq("stall_out_valid", out_valid, 1);
        out_ready = 1'b1;
        wait_idle(20);
        check_eq("stall_prod", prods[prods.size()-1], 32'h1234 * 32'hAB);

        // Reset pulse in RUN cycle 8 aborts the request.
        done_before = n_done;
        in0_a = 16'd5; in0_b = 16'd6; in0_valid = 1'b1;
        tick();
        repeat (8) tick();
        rst_n = 1'b0;
        in0_valid = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (W + 4) tick();
        check_eq("abort_no_result", n_done - done_before, 0);
        in1_a = 16'd0; in1_b = 16'h1234; in1_valid = 1'b1;
        wait_idle(60);
        check_eq("abort_next_prod", prods[prods.size()-1], 0);

        // Both ports continuously valid: grants alternate starting with port 0.
        s = grants.size();
        k = 0;
        while (grants.size() < s + 6 && k < 400) begin
            if (!in0_valid) begin in0_a = rand_op(); in0_b = rand_op(); in0_valid = 1'b1; end
            if (!in1_valid) begin in1_a = rand_op(); in1_b = rand_op(); in1_valid = 1'b1; end
            tick();
            k++;
        end
        check_eq("alt_count", grants.size() - s, 6);
        for (int i = 0; i < 6 && s + i < grants.size(); i++) begin
            check_eq($sformatf("alt_grant%0d", i), grants[s+i], i % 2);
        end
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        wait_idle(60);

        // Random traffic with random consumer back-pressure.
        for (int i = 0; i < 1500; i++) begin
            if (!in0_valid && ($urandom % 3) == 0) begin
                in0_a = rand_op(); in0_b = rand_op(); in0_valid = 1'b1;
            end
            if (!in1_valid && ($urandom % 3) == 0) begin
                in1_a = rand_op(); in1_b = rand_op(); in1_valid = 1'b1;
            end
            out_ready = ($urandom % 4) != 0;
            tick();
        end
        out_ready = 1'b1;
        wait_idle(200);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
